// File: rtl/lsu.sv
// lsu: load/store unit between the execute stage and a word-wide data memory.
// Accepts one load/store per request handshake, issues word-aligned beats with
// byte strobes, and aligns/extends read data.
// Optional feature: define LSU_MISALIGN_EN to split word-crossing misaligned
// accesses into two beats; without it any access not aligned to its size faults.
module lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_rsp_valid,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_fault,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

`ifdef LSU_MISALIGN_EN
    typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_WAIT0, S_BEAT1, S_WAIT1, S_RESP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_WAIT0, S_RESP} state_t;
`endif

    state_t            state_q, state_d;
    logic              write_q, uns_q, fault_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] base_q;
    logic [XLEN-1:0]   wdata_q, rd0_q;
`ifdef LSU_MISALIGN_EN
    logic              split_q;
    logic [XLEN-1:0]   rd1_q;
    logic              req_split;
    logic [XLEN-1:0]   beat1_wdata;
    logic [NB-1:0]     beat1_strb;
`endif

    logic              req_fault;
    logic [3:0]        req_bytes;
    logic [XLEN-1:0]   beat0_wdata, ld_raw, ld_ext;
    logic [NB-1:0]     beat0_strb;
    logic              sgn;
    int unsigned       off_i, bytes_i;

    // Classify an incoming request: size legality, alignment and word crossing.
    always_comb begin
        req_bytes = 4'd1 << i_req_size;
        req_fault = (XLEN == 32) && (i_req_size == 2'd3);
`ifdef LSU_MISALIGN_EN
        req_split = (5'(i_req_addr[OFF_W-1:0]) + 5'(req_bytes)) > 5'(NB);
`else
        if ((i_req_addr[2:0] & 3'(req_bytes - 4'd1)) != 3'd0) req_fault = 1'b1;
`endif
    end

    // Lane-shifted write data/strobes per beat and load byte assembly + extension.
    always_comb begin
        off_i       = 32'(off_q);
        bytes_i     = 32'd1 << size_q;
        beat0_wdata = wdata_q << (8 * off_i);
        ld_raw      = '0;
`ifdef LSU_MISALIGN_EN
        beat1_wdata = wdata_q >> (XLEN - 8 * off_i);
`endif
        for (int unsigned i = 0; i < NB; i++) begin
            beat0_strb[i] = (i >= off_i) && (i < off_i + bytes_i);
`ifdef LSU_MISALIGN_EN
            beat1_strb[i] = (i + NB) < (off_i + bytes_i);
`endif
            if (off_i + i < NB) begin
                ld_raw[8*i +: 8] = rd0_q[8*(off_i+i) +: 8];
            end else begin
`ifdef LSU_MISALIGN_EN
                ld_raw[8*i +: 8] = rd1_q[8*(off_i+i-NB) +: 8];
`else
                ld_raw[8*i +: 8] = 8'h00;
`endif
            end
        end
        case (size_q)
            2'd0:    sgn = ld_raw[7];
            2'd1:    sgn = ld_raw[15];
            default: sgn = ld_raw[31];
        endcase
        for (int unsigned b = 0; b < XLEN; b++) begin
            ld_ext[b] = (b < 8 * bytes_i) ? ld_raw[b] : (sgn & ~uns_q);
        end
    end

    // Next-state and port outputs; every output is forced low while reset is held.
    always_comb begin
        state_d     = state_q;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = '0;
        o_rsp_fault = 1'b0;
        o_mem_valid = 1'b0;
        o_mem_write = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wstrb = '0;
        if (!i_rst) begin
            case (state_q)
                S_IDLE: begin
                    o_req_ready = 1'b1;
                    if (i_req_valid) state_d = req_fault ? S_RESP : S_BEAT0;
                end
                S_BEAT0: begin
                    o_mem_valid = 1'b1;
                    o_mem_write = write_q;
                    o_mem_addr  = base_q;
                    o_mem_wdata = write_q ? beat0_wdata : '0;
                    o_mem_wstrb = beat0_strb;
                    if (i_mem_ready) begin
                        if (!write_q) state_d = S_WAIT0;
`ifdef LSU_MISALIGN_EN
                        else if (split_q) state_d = S_BEAT1;
`endif
                        else state_d = S_RESP;
                    end
                end
                S_WAIT0: begin
                    if (i_mem_rvalid) begin
`ifdef LSU_MISALIGN_EN
                        state_d = split_q ? S_BEAT1 : S_RESP;
`else
                        state_d = S_RESP;
`endif
                    end
                end
`ifdef LSU_MISALIGN_EN
                S_BEAT1: begin
                    o_mem_valid = 1'b1;
                    o_mem_write = write_q;
                    o_mem_addr  = base_q + ADDR_W'(NB);
                    o_mem_wdata = write_q ? beat1_wdata : '0;
                    o_mem_wstrb = beat1_strb;
                    if (i_mem_ready) state_d = write_q ? S_RESP : S_WAIT1;
                end
                S_WAIT1: begin
                    if (i_mem_rvalid) state_d = S_RESP;
                end
`endif
                S_RESP: begin
                    o_rsp_valid = 1'b1;
                    o_rsp_fault = fault_q;
                    o_rsp_rdata = (write_q || fault_q) ? '0 : ld_ext;
                    state_d     = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register, request capture at accept and read-data capture per wait state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            fault_q <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
`ifdef LSU_MISALIGN_EN
            split_q <= 1'b0;
            rd1_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && i_req_valid) begin
                write_q <= i_req_write;
                uns_q   <= i_req_unsigned;
                fault_q <= req_fault;
                size_q  <= i_req_size;
                off_q   <= i_req_addr[OFF_W-1:0];
                base_q  <= {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                wdata_q <= i_req_wdata;
`ifdef LSU_MISALIGN_EN
                split_q <= req_split;
`endif
            end
            if (state_q == S_WAIT0 && i_mem_rvalid) rd0_q <= i_mem_rdata;
`ifdef LSU_MISALIGN_EN
            if (state_q == S_WAIT1 && i_mem_rvalid) rd1_q <= i_mem_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu (XLEN=32). A byte-array memory answers the DUT's
// beats; a second byte array is updated by a byte-level reference model.
module tb_lsu;
    localparam int MEMSZ  = 264;
    localparam int BUDGET = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_write, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] dmem [MEMSZ];
    logic [7:0] rmem [MEMSZ];

    logic [31:0] r_rdata, r_b0_addr, r_b0_wdata, r_b1_addr;
    logic [3:0]  r_b0_wstrb;
    logic        r_fault, r_stable, r_addr_ok, r_rdy_start, r_rsp_low, r_timeout;
    int          r_nbeats, r_lat, r_beat_cycles;

    lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_fault(rsp_fault),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_write(mem_write),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] v = '0;
        for (int i = 0; i < 4; i++) if (a + 32'(i) < MEMSZ) v[8*i +: 8] = dmem[a + 32'(i)];
        return v;
    endfunction

    task automatic set_word(input int a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            dmem[a+i] = v[8*i +: 8];
            rmem[a+i] = v[8*i +: 8];
        end
    endtask

    function automatic bit model_fault(input logic [31:0] a, input logic [1:0] sz);
        int n = 1 << sz;
        if (sz == 2'd3) return 1'b1;
`ifdef LSU_MISALIGN_EN
        return (n == 0);
`else
        return (a % n) != 0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int n = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(rmem[a + 32'(i)]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) rmem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    function automatic int mem_diff();
        for (int i = 0; i < MEMSZ; i++) if (dmem[i] !== rmem[i]) return i;
        return -1;
    endfunction

    // Issues one request at the next negedge and plays memory until the response.
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int stall, input int rdly);
        int stall_cnt = 0, rd_cnt = 0;
        bit in_beat = 0, rd_pend = 0, done = 0;
        logic [31:0] rd_addr = '0, cap_addr = '0, cap_wdata = '0;
        logic [3:0]  cap_strb = '0;
        logic        cap_write = 1'b0;
        r_nbeats = 0; r_lat = 0; r_beat_cycles = 0; r_stable = 1; r_addr_ok = 1;
        r_timeout = 0; r_rdata = '0; r_fault = 0;
        r_b0_addr = '0; r_b0_wdata = '0; r_b0_wstrb = '0; r_b1_addr = '0;
        @(negedge clk);
        r_rdy_start = req_ready;
        r_rsp_low   = !rsp_valid;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= BUDGET && !done; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
            req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            if (rd_pend && rd_cnt == 0) begin
                mem_rvalid = 1'b1; mem_rdata = word_at(rd_addr); rd_pend = 0;
            end else begin
                mem_rvalid = 1'b0; mem_rdata = $urandom;
                if (rd_pend) rd_cnt--;
            end
            mem_ready = 1'b0;
            if (mem_valid) begin
                r_beat_cycles++;
                if (!in_beat) begin
                    in_beat = 1; stall_cnt = stall;
                    cap_addr = mem_addr; cap_wdata = mem_wdata; cap_strb = mem_wstrb; cap_write = mem_write;
                    if (r_nbeats == 0) begin
                        r_b0_addr = mem_addr; r_b0_wdata = mem_wdata; r_b0_wstrb = mem_wstrb;
                    end else r_b1_addr = mem_addr;
                    if (mem_addr[1:0] != 2'b00) r_addr_ok = 0;
                end else if ({mem_addr, mem_wdata, mem_wstrb, mem_write} !== {cap_addr, cap_wdata, cap_strb, cap_write})
                    r_stable = 0;
                if (stall_cnt == 0) mem_ready = 1'b1;
                else stall_cnt--;
            end
            #1;
            if (rsp_valid) begin
                r_rdata = rsp_rdata; r_fault = rsp_fault; r_lat = cyc; done = 1;
            end else if (mem_valid && mem_ready) begin
                r_nbeats++; in_beat = 0;
                if (mem_write) begin
                    for (int i = 0; i < 4; i++)
                        if (mem_wstrb[i] && mem_addr + 32'(i) < MEMSZ) dmem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
                end else begin
                    rd_pend = 1; rd_cnt = rdly; rd_addr = mem_addr;
                end
            end
        end
        if (!done) r_timeout = 1;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_addr = '0; req_wdata = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            n_errors++; $display("FAIL reset_outputs: ready=%b rsp_valid=%b mem_valid=%b addr=%h, want all 0", req_ready, rsp_valid, mem_valid, mem_addr);
        end
        @(negedge clk); rst = 1'b0; #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_checks++;
        if ({rsp_valid, mem_valid} !== 2'b00) begin n_errors++; $display("FAIL reset_idle: rsp_valid=%b mem_valid=%b want 0 0", rsp_valid, mem_valid); end
    endtask

    task automatic test_aligned_load();
        set_word(0, 32'hdeadbeef);
        run_access(1'b0, 2'd2, 1'b0, 32'd0, '0, 0, 1);
        n_checks++; if (r_timeout) begin n_errors++; $display("FAIL lw_timeout: no response in %0d cycles", BUDGET); end
        n_checks++; if (r_rdata !== 32'hdeadbeef) begin n_errors++; $display("FAIL lw_rdata: got %h want deadbeef", r_rdata); end
        n_checks++; if (r_fault !== 1'b0) begin n_errors++; $display("FAIL lw_fault: got %b want 0", r_fault); end
        n_checks++; if (r_lat != 4) begin n_errors++; $display("FAIL lw_latency: got %0d want 4", r_lat); end
        n_checks++; if (r_b0_addr !== 32'd0) begin n_errors++; $display("FAIL lw_addr: got %h want 0", r_b0_addr); end
    endtask

    task automatic test_byte_load();
        run_access(1'b0, 2'd0, 1'b0, 32'd3, '0, 0, 0);
        n_checks++; if (r_b0_addr !== 32'd0) begin n_errors++; $display("FAIL lb_addr: got %h want 0", r_b0_addr); end
        n_checks++; if (r_rdata !== 32'hffffffde) begin n_errors++; $display("FAIL lb_rdata: got %h want ffffffde", r_rdata); end
        run_access(1'b0, 2'd0, 1'b1, 32'd3, '0, 0, 2);
        n_checks++; if (r_rdata !== 32'h000000de) begin n_errors++; $display("FAIL lbu_rdata: got %h want 000000de", r_rdata); end
    endtask

    task automatic test_half_store();
        int d;
        model_store(32'd10, 2'd1, 32'h0000b0ba);
        run_access(1'b1, 2'd1, 1'b0, 32'd10, 32'h0000b0ba, 0, 0);
        n_checks++; if (r_b0_addr !== 32'd8) begin n_errors++; $display("FAIL sh_addr: got %h want 8", r_b0_addr); end
        n_checks++; if (r_b0_wdata !== 32'hb0ba0000) begin n_errors++; $display("FAIL sh_wdata: got %h want b0ba0000", r_b0_wdata); end
        n_checks++; if (r_b0_wstrb !== 4'b1100) begin n_errors++; $display("FAIL sh_wstrb: got %b want 1100", r_b0_wstrb); end
        n_checks++; if (r_lat != 2) begin n_errors++; $display("FAIL sh_latency: got %0d want 2", r_lat); end
        n_checks++; if (r_rdata !== '0) begin n_errors++; $display("FAIL sh_rdata: got %h want 0", r_rdata); end
        d = mem_diff();
        n_checks++; if (d != -1) begin n_errors++; $display("FAIL sh_memory: byte %0d got %h want %h", d, dmem[d], rmem[d]); end
    endtask

    task automatic test_backpressure();
        set_word(16, 32'hcafeb0ba);
        run_access(1'b0, 2'd1, 1'b1, 32'd18, '0, 3, 1);
        n_checks++; if (r_b0_addr !== 32'd16) begin n_errors++; $display("FAIL bp_addr: got %h want 10", r_b0_addr); end
        n_checks++; if (r_stable !== 1'b1) begin n_errors++; $display("FAIL bp_stable: got %b want 1", r_stable); end
        n_checks++; if (r_beat_cycles != 4) begin n_errors++; $display("FAIL bp_beat_cycles: got %0d want 4", r_beat_cycles); end
        n_checks++; if (r_rdata !== 32'h0000cafe) begin n_errors++; $display("FAIL bp_rdata: got %h want 0000cafe", r_rdata); end
    endtask

    task automatic test_misaligned();
        set_word(4, 32'h11223344);
        set_word(8, 32'h55667788);
        run_access(1'b0, 2'd2, 1'b0, 32'd6, '0, 1, 1);
`ifdef LSU_MISALIGN_EN
        n_checks++; if (r_nbeats != 2) begin n_errors++; $display("FAIL mis_beats: got %0d want 2", r_nbeats); end
        n_checks++; if ({r_b0_addr, r_b1_addr} !== {32'd4, 32'd8}) begin n_errors++; $display("FAIL mis_addrs: got %h %h want 4 8", r_b0_addr, r_b1_addr); end
        n_checks++; if (r_rdata !== 32'h77881122) begin n_errors++; $display("FAIL mis_rdata: got %h want 77881122", r_rdata); end
        n_checks++; if (r_fault !== 1'b0) begin n_errors++; $display("FAIL mis_fault: got %b want 0", r_fault); end
`else
        n_checks++; if (r_fault !== 1'b1) begin n_errors++; $display("FAIL mis_fault: got %b want 1", r_fault); end
        n_checks++; if (r_lat != 1) begin n_errors++; $display("FAIL mis_latency: got %0d want 1", r_lat); end
        n_checks++; if (r_beat_cycles != 0) begin n_errors++; $display("FAIL mis_no_beat: got %0d beat cycles want 0", r_beat_cycles); end
        n_checks++; if (r_rdata !== '0) begin n_errors++; $display("FAIL mis_rdata: got %h want 0", r_rdata); end
`endif
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'd0;
        @(negedge clk);
        req_valid = 1'b0; #1;
        n_checks++; if (mem_valid !== 1'b1) begin n_errors++; $display("FAIL rw_beat: mem_valid got %b want 1", mem_valid); end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; rst = 1'b1; #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            n_errors++; $display("FAIL rw_reset_outputs: ready=%b rsp_valid=%b mem_valid=%b want all 0", req_ready, rsp_valid, mem_valid);
        end
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
        n_checks++; if ({req_ready, rsp_valid, mem_valid} !== 3'b100) begin n_errors++; $display("FAIL rw_after_reset: ready/rsp/mem got %b want 100", {req_ready, rsp_valid, mem_valid}); end
        @(negedge clk);
        mem_rvalid = 1'b0; #1;
        n_checks++; if ({req_ready, rsp_valid} !== 2'b10) begin n_errors++; $display("FAIL rw_stale_rvalid: ready/rsp got %b want 10", {req_ready, rsp_valid}); end
        run_access(1'b0, 2'd2, 1'b0, 32'd0, '0, 0, 0);
        n_checks++; if (r_rdata !== 32'hdeadbeef) begin n_errors++; $display("FAIL rw_next_lw: got %h want deadbeef", r_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        for (int k = 0; k < 4; k++) begin
            wd = $urandom;
            model_store(32'(40 + 4 * k), 2'd2, wd);
            run_access(1'b1, 2'd2, 1'b0, 32'(40 + 4 * k), wd, 0, 0);
            n_checks++; if (r_lat != 2) begin n_errors++; $display("FAIL b2b_latency[%0d]: got %0d want 2", k, r_lat); end
            if (k > 0) begin
                n_checks++;
                if ({r_rdy_start, r_rsp_low} !== 2'b11) begin
                    n_errors++; $display("FAIL b2b_ready[%0d]: ready/rsp_low after RESP got %b want 11", k, {r_rdy_start, r_rsp_low});
                end
            end
        end
        n_checks++; if (mem_diff() != -1) begin n_errors++; $display("FAIL b2b_memory: byte %0d differs", mem_diff()); end
    endtask

    task automatic test_random();
        logic        wr, uns, ef;
        logic [1:0]  sz;
        logic [31:0] a, wd, er;
        int          eb, d;
        for (int it = 0; it < 150; it++) begin
            wr = 1'($urandom); uns = 1'($urandom);
            sz = 2'($urandom_range(3, 0));
            if (sz == 2'd3 && $urandom_range(3, 0) != 0) sz = 2'd2;
            a = $urandom_range(247, 0); wd = $urandom;
            ef = model_fault(a, sz);
            er = (wr || ef) ? '0 : model_load(a, sz, uns);
            eb = ef ? 0 : (((a % 4) + (1 << sz)) > 4 ? 2 : 1);
            if (!ef && wr) model_store(a, sz, wd);
            run_access(wr, sz, uns, a, wd, $urandom_range(3, 0), $urandom_range(3, 0));
            n_checks++;
            if ({r_timeout, r_fault, r_stable, r_addr_ok, r_rdy_start} !== {1'b0, ef, 1'b1, 1'b1, 1'b1}) begin
                n_errors++; $display("FAIL rnd_status[%0d]: timeout/fault/stable/addr_ok/ready got %b want %b", it,
                    {r_timeout, r_fault, r_stable, r_addr_ok, r_rdy_start}, {1'b0, ef, 1'b1, 1'b1, 1'b1});
            end
            n_checks++;
            if (r_rdata !== er) begin n_errors++; $display("FAIL rnd_rdata[%0d]: wr=%b sz=%0d addr=%0d got %h want %h", it, wr, sz, a, r_rdata, er); end
            n_checks++;
            if (r_nbeats != eb) begin n_errors++; $display("FAIL rnd_beats[%0d]: addr=%0d sz=%0d got %0d want %0d", it, a, sz, r_nbeats, eb); end
            if (wr) begin
                d = mem_diff();
                n_checks++;
                if (d != -1) begin n_errors++; $display("FAIL rnd_memory[%0d]: byte %0d got %h want %h", it, d, dmem[d], rmem[d]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) begin
            dmem[i] = 8'($urandom);
            rmem[i] = dmem[i];
        end
        test_reset();
        test_aligned_load();
        test_byte_load();
        test_half_store();
        test_backpressure();
        test_misaligned();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
